// File: rtl/mem_wb_stage_if.sv
// Memory/write-back boundary bus. The memory stage drives the instruction
// fields (master); the write-back register consumes them and returns the
// register-file write port plus status (slave).
interface mem_wb_stage_if #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
);
  logic              in_valid;
  logic              DC_Stall;
  logic [DATA_W-1:0] MemOut;
  logic [DATA_W-1:0] XOut;
  logic [DATA_W-1:0] PCInc;
  logic [1:0]        WBSel;
  logic              RegWrite;
  logic [REG_W-1:0]  WriteReg;
  logic              Halt;
  logic              mem_err;

  logic [DATA_W-1:0] WBData;
  logic              WBRegWrite;
  logic [REG_W-1:0]  WBWriteReg;
  logic              WBValid;
  logic              Halted;
  logic              err;
  logic [15:0]       retire_cnt;

  modport master (
    output in_valid, DC_Stall, MemOut, XOut, PCInc, WBSel,
           RegWrite, WriteReg, Halt, mem_err,
    input  WBData, WBRegWrite, WBWriteReg, WBValid, Halted, err, retire_cnt
  );

  modport slave (
    input  in_valid, DC_Stall, MemOut, XOut, PCInc, WBSel,
           RegWrite, WriteReg, Halt, mem_err,
    output WBData, WBRegWrite, WBWriteReg, WBValid, Halted, err, retire_cnt
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with halt/error drain FSM and a saturating
// retirement counter. One instruction is captured per non-stalled valid
// cycle and retires on the following cycle.
module mem_wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input logic          clk,
  input logic          rst,
  mem_wb_stage_if.slave bus
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] memout_q, xout_q, pcinc_q;
  logic [1:0]        wbsel_q;
  logic              regwrite_q, halt_q;
  logic [REG_W-1:0]  writereg_q;
  logic              valid_q, halted_q, err_q;
  logic [15:0]       cnt_q, cnt_d;

  logic capture, err_cond;

  // Stall wins over valid; nothing is captured outside RUN.
  assign capture  = (state_q == RUN) & bus.in_valid & ~bus.DC_Stall;
  // Either a memory fault or a write with the illegal source select.
  assign err_cond = bus.mem_err | (bus.RegWrite & (bus.WBSel == 2'b11));

  // Counter saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  // Pipeline register, drain FSM, sticky error and retire counter.
  // The counter advances on the capture edge so it already includes the
  // instruction shown on WBValid in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RUN;
      memout_q   <= '0;
      xout_q     <= '0;
      pcinc_q    <= '0;
      wbsel_q    <= '0;
      regwrite_q <= 1'b0;
      writereg_q <= '0;
      halt_q     <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        RUN: begin
          valid_q <= capture;
          if (capture) begin
            memout_q   <= bus.MemOut;
            xout_q     <= bus.XOut;
            pcinc_q    <= bus.PCInc;
            wbsel_q    <= bus.WBSel;
            regwrite_q <= bus.RegWrite;
            writereg_q <= bus.WriteReg;
            halt_q     <= bus.Halt;
            cnt_q      <= cnt_d;
            if (err_cond) err_q <= 1'b1;
            if (bus.Halt | err_cond) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
          state_q  <= HALTED;
        end
        HALTED: begin
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
        end
        default: begin
          valid_q  <= 1'b0;
          halted_q <= 1'b1;
          state_q  <= HALTED;
        end
      endcase
    end
  end

  // Write-back source mux; the illegal select falls back to XOut.
  always_comb begin
    bus.WBData = xout_q;
    case (wbsel_q)
      2'b01:   bus.WBData = memout_q;
      2'b10:   bus.WBData = pcinc_q;
      default: bus.WBData = xout_q;
    endcase
  end

  assign bus.WBRegWrite = valid_q & regwrite_q & ~halt_q & (wbsel_q != 2'b11);
  assign bus.WBWriteReg = writereg_q;
  assign bus.WBValid    = valid_q;
  assign bus.Halted     = halted_q;
  assign bus.err        = err_q;
  assign bus.retire_cnt = cnt_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: a vector table for single-cycle
// capture/bubble behaviour, then hand sequences for stall, halt, error,
// reset and counter saturation.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mem_wb_stage_if #(.DATA_W(16), .REG_W(3)) bus ();
  mem_wb_stage #(.DATA_W(16), .REG_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic        st;
    logic [15:0] mem;
    logic [15:0] x;
    logic [15:0] pc;
    logic [1:0]  sel;
    logic        rw;
    logic [2:0]  wr;
    logic        e_valid;
    logic [15:0] e_data;
    logic        e_rw;
    logic [2:0]  e_wr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic st, input logic [15:0] mem,
                       input logic [15:0] x, input logic [15:0] pc, input logic [1:0] sel,
                       input logic rw, input logic [2:0] wr, input logic h, input logic me);
    bus.in_valid = iv; bus.DC_Stall = st; bus.MemOut = mem; bus.XOut = x;
    bus.PCInc = pc; bus.WBSel = sel; bus.RegWrite = rw; bus.WriteReg = wr;
    bus.Halt = h; bus.mem_err = me;
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    idle();
    step();
    rst = 1'b1;
  endtask

  initial begin
    //          iv   st   mem      x        pc       sel    rw   wr    valid data     rw   wr    cnt
    vecs[0] = '{1'b1,1'b0,16'hBEEF,16'h1234,16'h0010,2'b01,1'b1,3'd5, 1'b1,16'hBEEF,1'b1,3'd5, 16'd1};
    vecs[1] = '{1'b1,1'b0,16'h1111,16'h00A5,16'h0012,2'b00,1'b1,3'd2, 1'b1,16'h00A5,1'b1,3'd2, 16'd2};
    vecs[2] = '{1'b1,1'b0,16'h2222,16'h3333,16'h0014,2'b10,1'b1,3'd7, 1'b1,16'h0014,1'b1,3'd7, 16'd3};
    vecs[3] = '{1'b1,1'b0,16'h5555,16'h4444,16'h0016,2'b00,1'b0,3'd3, 1'b1,16'h4444,1'b0,3'd3, 16'd4};
    vecs[4] = '{1'b0,1'b0,16'h9999,16'h8888,16'h7777,2'b01,1'b1,3'd6, 1'b0,16'h4444,1'b0,3'd3, 16'd4};
    vecs[5] = '{1'b1,1'b1,16'h9999,16'h8888,16'hAAAA,2'b10,1'b1,3'd1, 1'b0,16'h4444,1'b0,3'd3, 16'd4};
    vecs[6] = '{1'b1,1'b0,16'h0000,16'h6666,16'h0018,2'b01,1'b1,3'd0, 1'b1,16'h0000,1'b1,3'd0, 16'd5};

    idle();
    #2;
    // Reset state, no clock edge yet
    chk("rst_valid",  {31'd0, bus.WBValid},    32'd0);
    chk("rst_rw",     {31'd0, bus.WBRegWrite}, 32'd0);
    chk("rst_halted", {31'd0, bus.Halted},     32'd0);
    chk("rst_err",    {31'd0, bus.err},        32'd0);
    chk("rst_cnt",    {16'd0, bus.retire_cnt}, 32'd0);
    chk("rst_data",   {16'd0, bus.WBData},     32'd0);
    chk("rst_wr",     {29'd0, bus.WBWriteReg}, 32'd0);
    step();
    rst = 1'b1;

    // Table-driven capture / bubble vectors
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].iv, vecs[i].st, vecs[i].mem, vecs[i].x, vecs[i].pc, vecs[i].sel,
            vecs[i].rw, vecs[i].wr, 1'b0, 1'b0);
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, bus.WBValid},    {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_data", i),  {16'd0, bus.WBData},     {16'd0, vecs[i].e_data});
      chk($sformatf("v%0d_rw", i),    {31'd0, bus.WBRegWrite}, {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d_wr", i),    {29'd0, bus.WBWriteReg}, {29'd0, vecs[i].e_wr});
      chk($sformatf("v%0d_cnt", i),   {16'd0, bus.retire_cnt}, {16'd0, vecs[i].e_cnt});
    end

    // Stall for 3 cycles, load data captured on the release edge
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 16'h1111 * (i + 1), 16'h0, 16'h0, 2'b01, 1'b1, 3'd5, 1'b0, 1'b0);
      step();
      chk($sformatf("stall%0d_valid", i), {31'd0, bus.WBValid},    32'd0);
      chk($sformatf("stall%0d_rw", i),    {31'd0, bus.WBRegWrite}, 32'd0);
    end
    drive(1'b1, 1'b0, 16'hC0DE, 16'h0, 16'h0, 2'b01, 1'b1, 3'd5, 1'b0, 1'b0);
    step();
    chk("release_valid", {31'd0, bus.WBValid},    32'd1);
    chk("release_data",  {16'd0, bus.WBData},     32'h0000C0DE);
    chk("release_rw",    {31'd0, bus.WBRegWrite}, 32'd1);
    chk("release_cnt",   {16'd0, bus.retire_cnt}, 32'd6);
    idle();
    step();
    chk("after_release_valid", {31'd0, bus.WBValid}, 32'd0);

    // Halt with RegWrite: retires without writing, then halts for good
    drive(1'b1, 1'b0, 16'h0, 16'h00AB, 16'h0020, 2'b00, 1'b1, 3'd4, 1'b1, 1'b0);
    step();
    chk("halt_valid",  {31'd0, bus.WBValid},    32'd1);
    chk("halt_rw",     {31'd0, bus.WBRegWrite}, 32'd0);
    chk("halt_drain",  {31'd0, bus.Halted},     32'd0);
    chk("halt_cnt",    {16'd0, bus.retire_cnt}, 32'd7);
    drive(1'b1, 1'b0, 16'h0, 16'h0FFF, 16'h0, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0);
    step();
    chk("halted_set",   {31'd0, bus.Halted},  32'd1);
    chk("halted_valid", {31'd0, bus.WBValid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'h0, 16'h0FFF, 16'h0, 2'b00, 1'b1, 3'd1, 1'b0, 1'b1);
      step();
      chk($sformatf("halted_ign%0d_valid", i), {31'd0, bus.WBValid},    32'd0);
      chk($sformatf("halted_ign%0d_rw", i),    {31'd0, bus.WBRegWrite}, 32'd0);
      chk($sformatf("halted_ign%0d_data", i),  {16'd0, bus.WBData},     32'h000000AB);
      chk($sformatf("halted_ign%0d_cnt", i),   {16'd0, bus.retire_cnt}, 32'd7);
      chk($sformatf("halted_ign%0d_err", i),   {31'd0, bus.err},        32'd0);
    end

    // mem_err on an ALU op: err, drain, halt; err sticky
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 16'h0042, 16'h0, 2'b00, 1'b1, 3'd2, 1'b0, 1'b1);
    step();
    chk("merr_err",    {31'd0, bus.err},     32'd1);
    chk("merr_valid",  {31'd0, bus.WBValid}, 32'd1);
    chk("merr_halted", {31'd0, bus.Halted},  32'd0);
    idle();
    step();
    chk("merr_halted2", {31'd0, bus.Halted}, 32'd1);
    step();
    step();
    chk("merr_sticky", {31'd0, bus.err},        32'd1);
    chk("merr_cnt",    {16'd0, bus.retire_cnt}, 32'd1);
    // Asynchronous reset mid-cycle while halted
    #2;
    rst = 1'b0;
    #1;
    chk("async_halted", {31'd0, bus.Halted},     32'd0);
    chk("async_err",    {31'd0, bus.err},        32'd0);
    chk("async_cnt",    {16'd0, bus.retire_cnt}, 32'd0);
    step();
    rst = 1'b1;

    // Halt and mem_err together: single drain then halt
    drive(1'b1, 1'b0, 16'h0, 16'h0007, 16'h0, 2'b00, 1'b1, 3'd3, 1'b1, 1'b1);
    step();
    chk("hm_err",   {31'd0, bus.err},        32'd1);
    chk("hm_valid", {31'd0, bus.WBValid},    32'd1);
    chk("hm_rw",    {31'd0, bus.WBRegWrite}, 32'd0);
    drive(1'b1, 1'b0, 16'h0, 16'h0008, 16'h0, 2'b00, 1'b1, 3'd3, 1'b0, 1'b0);
    step();
    chk("hm_halted", {31'd0, bus.Halted},     32'd1);
    chk("hm_valid2", {31'd0, bus.WBValid},    32'd0);
    chk("hm_cnt",    {16'd0, bus.retire_cnt}, 32'd1);

    // Illegal select with RegWrite: err, no write, data from XOut; reset during drain
    do_reset();
    drive(1'b1, 1'b0, 16'h1357, 16'h2468, 16'h0AAA, 2'b11, 1'b1, 3'd6, 1'b0, 1'b0);
    step();
    chk("ill_err",   {31'd0, bus.err},        32'd1);
    chk("ill_valid", {31'd0, bus.WBValid},    32'd1);
    chk("ill_rw",    {31'd0, bus.WBRegWrite}, 32'd0);
    chk("ill_data",  {16'd0, bus.WBData},     32'h00002468);
    rst = 1'b0;
    #1;
    chk("drain_rst_valid", {31'd0, bus.WBValid}, 32'd0);
    chk("drain_rst_err",   {31'd0, bus.err},     32'd0);
    chk("drain_rst_data",  {16'd0, bus.WBData},  32'd0);
    #2;
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0, 16'h0055, 16'h0, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0);
    step();
    chk("resume_valid",  {31'd0, bus.WBValid},    32'd1);
    chk("resume_data",   {16'd0, bus.WBData},     32'h00000055);
    chk("resume_halted", {31'd0, bus.Halted},     32'd0);

    // Counter saturation
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 16'h0001, 16'h0, 2'b00, 1'b1, 3'd1, 1'b0, 1'b0);
    for (int i = 0; i < 65534; i++) step();
    chk("cnt_fffe", {16'd0, bus.retire_cnt}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("cnt_sat%0d", i), {16'd0, bus.retire_cnt}, 32'h0000FFFF);
      chk($sformatf("cnt_sat%0d_valid", i), {31'd0, bus.WBValid}, 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter: DATA_W, 16, datapath width.
REQ-002 Parameter: REG_W, 3, register-specifier width.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  instruction present at memory-stage output.
REQ-006 DC_Stall  input  1  data-cache stall from memory stage.
REQ-007 MemOut  input  DATA_W  load data from memory stage.
REQ-008 XOut  input  DATA_W  execute result / effective address.
REQ-009 PCInc  input  DATA_W  PC+2 of the instruction.
REQ-010 WBSel  input  2  write-back source select: 00 XOut, 01 MemOut, 10 PCInc, 11 illegal.
REQ-011 RegWrite  input  1  instruction writes the register file.
REQ-012 WriteReg  input  REG_W  destination register.
REQ-013 Halt  input  1  instruction is HALT.
REQ-014 mem_err  input  1  error flag from memory stage.
REQ-015 WBData  output  DATA_W  register-file write data.
REQ-016 WBRegWrite  output  1  register-file write enable.
REQ-017 WBWriteReg  output  REG_W  register-file write address.
REQ-018 WBValid  output  1  an instruction retires this cycle.
REQ-019 Halted  output  1  processor halted.
REQ-020 err  output  1  sticky error flag.
REQ-021 retire_cnt  output  16  retired-instruction count.

Function
REQ-022 FSM states: RUN, DRAIN, HALTED; encoding is free.
REQ-023 Capture: in RUN, on a rising edge with in_valid=1 and DC_Stall=0, register MemOut, XOut, PCInc, WBSel, RegWrite, WriteReg, Halt and mem_err, and set WBValid=1 next cycle (latency 1).
REQ-024 Bubble: in RUN, with DC_Stall=1 or in_valid=0, drive WBValid=0 and WBRegWrite=0 next cycle, and hold the data fields.
REQ-025 WBData is a combinational mux of the registered fields per the registered WBSel; 11 yields the registered XOut.
REQ-026 WBRegWrite = WBValid & registered RegWrite & ~registered Halt & (registered WBSel != 11).
REQ-027 err sets on any captured instruction with mem_err=1, or with RegWrite=1 and WBSel=11.
REQ-028 err stays set until reset.
REQ-029 RUN -> DRAIN on capture of an instruction with Halt=1 or with an err-setting condition.
REQ-030 DRAIN lasts exactly one cycle, with that instruction retiring (WBValid=1), then moves to HALTED.
REQ-031 HALTED: Halted=1, WBValid=0, WBRegWrite=0, all inputs ignored, no exit except reset.
REQ-032 In DRAIN, inputs are not captured; the next cycle is a bubble.
REQ-033 retire_cnt increments by 1 on every cycle with WBValid=1.
REQ-034 retire_cnt saturates at 16'hFFFF and does not wrap.
REQ-035 Halt=1 and mem_err=1 together: err set, halt path taken once, single DRAIN cycle.
REQ-036 DC_Stall=1 takes priority over in_valid=1: no capture and no retirement.

Reset
REQ-037 While rst=0, regardless of clk: state=RUN; WBValid=0, WBRegWrite=0, Halted=0, err=0, retire_cnt=0.
REQ-038 While rst=0, all registered data fields are 0, so WBData=0 and WBWriteReg=0.
REQ-039 Reset asserted mid-DRAIN or in HALTED clears to RUN immediately.
REQ-040 Capture resumes on the first rising edge after rst returns high.

Verification
REQ-041 Load with WBSel=01, MemOut=16'hBEEF, RegWrite=1, WriteReg=5, DC_Stall=0 -> next cycle WBData=16'hBEEF, WBRegWrite=1, WBWriteReg=5, retire_cnt=1.
REQ-042 Same load with DC_Stall=1 for 3 cycles, then 0 -> 3 cycles WBValid=0, then one retirement with MemOut captured on the release edge.
REQ-043 Halt=1 with RegWrite=1 -> next cycle WBValid=1, WBRegWrite=0; following cycle Halted=1; later in_valid pulses cause no change.
REQ-044 mem_err=1 on an ALU instruction -> err=1 next cycle, DRAIN, then HALTED; err stays 1 until rst=0.
REQ-045 Preload retire_cnt to 16'hFFFE via 65534 retirements, then retire 3 more -> retire_cnt=16'hFFFF.
REQ-046 Assert rst=0 mid-cycle while in HALTED -> Halted=0, err=0, retire_cnt=0 without any clk edge.
